// File: rtl/cru_pkg.sv
// Shared types and default divide ratios for the cascaded clock-enable unit.
// Default chain: 240 MHz / 5 = 48 MHz, / 50 = 960 kHz, / 30 = 32 kHz.
package cru_pkg;

    localparam int DIV_W = 8;

    typedef logic [DIV_W-1:0] div_t;

    localparam div_t DIV_48M  = 8'd5;
    localparam div_t DIV_960K = 8'd50;
    localparam div_t DIV_32K  = 8'd30;

    // Stage 0 sits in the least significant byte.
    localparam logic [3*DIV_W-1:0] DIV_INIT_DEF = {DIV_32K, DIV_960K, DIV_48M};

    // A ratio of zero would never wrap, so it is treated as a pass-through.
    function automatic div_t clamp_div(input div_t d);
        return (d == '0) ? div_t'(1) : d;
    endfunction

endpackage

// File: rtl/cru_stage.sv
// One divider stage: counts parent ticks and emits a combinational tick on wrap.
// A pending ratio is swapped in only at wrap, so every period runs on a single ratio.
module cru_stage #(
    parameter int                   DIV_WIDTH = 8,
    parameter logic [DIV_WIDTH-1:0] DIV_RST   = DIV_WIDTH'(1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 hold,
    input  logic                 parent,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] load_div,
    output logic                 tick
);

    localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] div;
    logic                 wrap;

    function automatic logic [DIV_WIDTH-1:0] clamp(input logic [DIV_WIDTH-1:0] d);
        return (d == '0) ? ONE : d;
    endfunction

    // div never holds zero, so div - 1 cannot underflow.
    assign wrap = (cnt == div - ONE);
    assign tick = parent & wrap & ~hold;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            div <= clamp(DIV_RST);
        end else if (hold) begin
            cnt <= '0;
        end else if (parent) begin
            if (wrap) begin
                cnt <= '0;
                if (load) begin
                    div <= clamp(load_div);
                end
            end else begin
                cnt <= cnt + ONE;
            end
        end
    end

endmodule

// File: rtl/cru_cascade.sv
// Clock/reset unit: reset synchroniser plus NUM_EN cascaded single-cycle enables
// whose divide ratios can be reprogrammed at run time, taking effect at stage wrap.
module cru_cascade
    import cru_pkg::*;
#(
    parameter int                          NUM_EN      = 3,
    parameter int                          DIV_WIDTH   = 8,
    parameter int                          SYNC_STAGES = 2,
    parameter logic [NUM_EN*DIV_WIDTH-1:0] DIV_INIT    = DIV_INIT_DEF,
    localparam int                         SEL_W       = (NUM_EN > 1) ? $clog2(NUM_EN) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 reset_sync,
    output logic [NUM_EN-1:0]    en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [SEL_W-1:0]     cfg_sel,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    output logic                 cfg_err
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hold;
    logic                   accept;
    logic                   sel_ok;
    logic                   load_fire;
    logic                   pend;
    logic                   pend_next;
    logic [SEL_W-1:0]       pend_sel;
    logic [DIV_WIDTH-1:0]   pend_div;
    logic [NUM_EN-1:0]      tick;
    logic [NUM_EN-1:0]      parent_v;
    logic [NUM_EN-1:0]      load_v;

    // Ones shift in after release; the output stays asserted until the last stage fills.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign reset_sync = ~sync_q[SYNC_STAGES-1];
    assign hold       = reset_sync;

    // Handshake: a request transfers on a clock edge where cfg_valid and cfg_ready are
    // both high; the master must hold cfg_valid/cfg_sel/cfg_div stable until then.
    // cfg_ready is low while a request is pending and returns the cycle after its load.
    assign accept    = cfg_valid & cfg_ready & ~hold;
    assign sel_ok    = (32'(cfg_sel) < NUM_EN);
    assign load_fire = |(load_v & tick);

    always_comb begin
        pend_next = pend;
        if (pend && load_fire) begin
            pend_next = 1'b0;
        end else if (accept && sel_ok) begin
            pend_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend      <= 1'b0;
            pend_sel  <= '0;
            pend_div  <= '0;
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
            en        <= '0;
        end else begin
            pend      <= pend_next;
            cfg_ready <= ~hold & ~pend_next;
            cfg_err   <= accept & ~sel_ok;
            en        <= hold ? '0 : tick;
            if (accept) begin
                pend_sel <= cfg_sel;
                pend_div <= cfg_div;
            end
        end
    end

    for (genvar i = 0; i < NUM_EN; i++) begin : g_stage
        if (i == 0) begin : g_root
            assign parent_v[i] = 1'b1;
        end else begin : g_child
            assign parent_v[i] = tick[i-1];
        end

        assign load_v[i] = pend & (pend_sel == SEL_W'(i));

        cru_stage #(
            .DIV_WIDTH (DIV_WIDTH),
            .DIV_RST   (DIV_INIT[i*DIV_WIDTH +: DIV_WIDTH])
        ) u_stage (
            .clk      (clk),
            .reset_n  (reset_n),
            .hold     (hold),
            .parent   (parent_v[i]),
            .load     (load_v[i]),
            .load_div (pend_div),
            .tick     (tick[i])
        );
    end

endmodule
